// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// hex-to-segment table, blank pattern and index-width helper.
package display_pkg;

    // Active-high g..a patterns; entry 15 (F) first so the index equals the hex value.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_seg7_decode.sv
// Combinational hex digit plus decimal point to active-high segment pattern.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = {dp, SEG_TABLE[value]};
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-segment scan driver with frame-synchronous shadow data,
// leading-zero suppression and PWM brightness with a blanked phase 0.
module display_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int DIV_LOG2       = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic [N_DIGITS-1:0]   en_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  lz_en_i,
    input  logic [3:0]            bright_i,
    output logic [7:0]            led_cx_o,
    output logic [N_DIGITS-1:0]   led_en_o,
    output logic                  frame_o
);

    localparam int IW = idx_width(N_DIGITS);
    localparam logic [7:0]          CX_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [N_DIGITS-1:0] EN_IDLE = (EN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_LOG2-1:0]   cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] sh_data;
    logic [N_DIGITS-1:0]   sh_en;
    logic [N_DIGITS-1:0]   sh_dp;
    logic                  sh_lz;
    logic [3:0]            sh_bright;

    logic                  cnt_max;
    logic                  idx_last;
    logic                  load;
    logic [3:0]            phase;
    logic [N_DIGITS-1:0]   supp;
    logic [3:0]            cur_val;
    logic [7:0]            seg_ah;
    logic                  lit;
    logic [7:0]            cx_next;
    logic [N_DIGITS-1:0]   en_next;

    assign cnt_max  = &cnt;
    assign idx_last = (idx == IW'(N_DIGITS - 1));
    assign load     = cnt_max && idx_last;
    assign phase    = cnt[DIV_LOG2-1 -: 4];
    assign cur_val  = sh_data[4*int'(idx) +: 4];

    // Walk from the most significant digit down; disabled digits leave the zero run intact.
    always_comb begin
        logic run;
        logic zero_k;
        supp   = '0;
        run    = 1'b1;
        zero_k = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_k  = (sh_data[4*k +: 4] == 4'd0) && !sh_dp[k];
            supp[k] = sh_lz && run && zero_k && (k != 0);
            if (sh_en[k]) begin
                run = run && zero_k;
            end
        end
    end

    seg7_decode u_decode (
        .value   (cur_val),
        .dp      (sh_dp[idx]),
        .pattern (seg_ah)
    );

    always_comb begin
        lit     = (phase != 4'd0) && (phase <= sh_bright) && sh_en[idx] && !supp[idx];
        cx_next = CX_IDLE;
        en_next = EN_IDLE;
        if (lit) begin
            cx_next = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
            en_next = (EN_ACTIVE_LOW != 0) ? ~(N_DIGITS'(1) << idx) : (N_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt       <= '0;
            idx       <= '0;
            sh_data   <= '0;
            sh_en     <= '0;
            sh_dp     <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= 4'd0;
            frame_o   <= 1'b0;
            led_cx_o  <= CX_IDLE;
            led_en_o  <= EN_IDLE;
        end else begin
            cnt     <= cnt + DIV_LOG2'(1);
            frame_o <= load;
            if (cnt_max) begin
                idx <= idx_last ? '0 : idx + IW'(1);
            end
            if (load) begin
                sh_data   <= data_i;
                sh_en     <= en_i;
                sh_dp     <= dp_i;
                sh_lz     <= lz_en_i;
                sh_bright <= bright_i;
            end
            led_cx_o <= cx_next;
            led_en_o <= en_next;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed table-driven bench for display_scan with 4 digits and 16-cycle slots.
module tb_display_scan;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] data_i;
    logic [3:0]  en_i;
    logic [3:0]  dp_i;
    logic        lz_en_i;
    logic [3:0]  bright_i;
    logic [7:0]  led_cx_o;
    logic [3:0]  led_en_o;
    logic        frame_o;

    int tests = 0;
    int fails = 0;
    int pos = 0;
    int onehot_errs = 0;

    always #5 clk = ~clk;

    display_scan #(
        .N_DIGITS(4), .DIV_LOG2(4), .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(0)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .en_i     (en_i),
        .dp_i     (dp_i),
        .lz_en_i  (lz_en_i),
        .bright_i (bright_i),
        .led_cx_o (led_cx_o),
        .led_en_o (led_en_o),
        .frame_o  (frame_o)
    );

    always @(negedge clk) begin
        if ($countones(led_en_o) > 1) begin
            onehot_errs++;
            $display("[TB] FAIL onehot: led_en_o=%b has more than one active bit", led_en_o);
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [3:0]  en;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  bright;
        int          slot;
        int          phase;
        logic [3:0]  exp_en;
        logic [7:0]  exp_cx;
    } vec_t;

    vec_t vecs[$];

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] e,
                                 input logic [3:0] p, input logic lz, input logic [3:0] b);
        data_i   = d;
        en_i     = e;
        dp_i     = p;
        lz_en_i  = lz;
        bright_i = b;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_en, input logic [7:0] exp_cx);
        tests++;
        if (led_en_o !== exp_en || led_cx_o !== exp_cx) begin
            fails++;
            $display("[TB] FAIL %s: en=%b cx=%h, expected en=%b cx=%h",
                     name, led_en_o, led_cx_o, exp_en, exp_cx);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        pos++;
    endtask

    task automatic waitFrame();
        int n;
        n = 0;
        stepCycle();
        while (frame_o !== 1'b1 && n < 200) begin
            stepCycle();
            n++;
        end
        if (frame_o !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL frame_timeout: no frame_o within 200 cycles");
        end
        pos = 0;
    endtask

    task automatic gotoSample(input int slot, input int phase);
        int target;
        target = 1 + 16*slot + phase;
        if (pos >= target) begin
            tests++;
            fails++;
            $display("[TB] FAIL sample_order: at %0d, requested %0d", pos, target);
        end
        while (pos < target) stepCycle();
    endtask

    // Releases reset and counts cycles to the first frame pulse, requiring darkness until then.
    task automatic releaseAndCount(input string name);
        int n;
        int dark_err;
        n = 0;
        dark_err = 0;
        rst_i = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (led_en_o !== 4'b0000 || led_cx_o !== 8'hFF) dark_err++;
            if (frame_o === 1'b1) break;
        end
        checkInt({name, "_first_frame"}, n, 64);
        checkInt({name, "_dark_before_frame"}, dark_err, 0);
        pos = 0;
    endtask

    task automatic addVec(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p,
                          input logic lz, input logic [3:0] b, input int s, input int ph,
                          input logic [3:0] xe, input logic [7:0] xc);
        vec_t v;
        v.data = d; v.en = e; v.dp = p; v.lz = lz; v.bright = b;
        v.slot = s; v.phase = ph; v.exp_en = xe; v.exp_cx = xc;
        vecs.push_back(v);
    endtask

    initial begin
        int lit_cnt;
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'hF, 0, 0,  4'b0000, 8'hFF);
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'hF, 0, 1,  4'b0001, 8'hC0);
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'hF, 1, 15, 4'b0010, 8'hF9);
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'hF, 2, 7,  4'b0100, 8'hA4);
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'hF, 3, 1,  4'b1000, 8'hB0);
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'h4, 1, 4,  4'b0010, 8'hF9);
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'h4, 1, 5,  4'b0000, 8'hFF);
        addVec(16'h3210, 4'hF, 4'h0, 1'b0, 4'h0, 0, 1,  4'b0000, 8'hFF);
        addVec(16'h0005, 4'hF, 4'h0, 1'b1, 4'hF, 3, 3,  4'b0000, 8'hFF);
        addVec(16'h0005, 4'hF, 4'h0, 1'b1, 4'hF, 1, 3,  4'b0000, 8'hFF);
        addVec(16'h0005, 4'hF, 4'h0, 1'b1, 4'hF, 0, 3,  4'b0001, 8'h92);
        addVec(16'h0005, 4'hF, 4'h4, 1'b1, 4'hF, 2, 2,  4'b0100, 8'h40);
        addVec(16'h0005, 4'hF, 4'h4, 1'b1, 4'hF, 1, 2,  4'b0010, 8'hC0);
        addVec(16'h0005, 4'hF, 4'h4, 1'b1, 4'hF, 3, 2,  4'b0000, 8'hFF);
        addVec(16'h0000, 4'hF, 4'h0, 1'b1, 4'hF, 0, 2,  4'b0001, 8'hC0);
        addVec(16'h0000, 4'hF, 4'h0, 1'b1, 4'hF, 1, 2,  4'b0000, 8'hFF);
        addVec(16'h0005, 4'hF, 4'h0, 1'b0, 4'hF, 3, 3,  4'b1000, 8'hC0);
        addVec(16'h5005, 4'h7, 4'h0, 1'b1, 4'hF, 2, 1,  4'b0000, 8'hFF);
        addVec(16'h5005, 4'h7, 4'h0, 1'b1, 4'hF, 0, 1,  4'b0001, 8'h92);
        addVec(16'h5005, 4'h7, 4'h0, 1'b1, 4'hF, 3, 1,  4'b0000, 8'hFF);
        addVec(16'h3210, 4'hA, 4'h0, 1'b0, 4'hF, 0, 5,  4'b0000, 8'hFF);
        addVec(16'h3210, 4'hA, 4'h0, 1'b0, 4'hF, 1, 5,  4'b0010, 8'hF9);
        addVec(16'h3210, 4'hA, 4'h0, 1'b0, 4'hF, 2, 5,  4'b0000, 8'hFF);
        addVec(16'h3210, 4'hA, 4'h0, 1'b0, 4'hF, 3, 5,  4'b1000, 8'hB0);
        addVec(16'hBA98, 4'hF, 4'h0, 1'b0, 4'hF, 0, 8,  4'b0001, 8'h80);
        addVec(16'hBA98, 4'hF, 4'h0, 1'b0, 4'hF, 1, 8,  4'b0010, 8'h90);
        addVec(16'hBA98, 4'hF, 4'h0, 1'b0, 4'hF, 2, 8,  4'b0100, 8'h88);
        addVec(16'hBA98, 4'hF, 4'h0, 1'b0, 4'hF, 3, 8,  4'b1000, 8'h83);
        addVec(16'hFEDC, 4'hF, 4'h0, 1'b0, 4'hF, 0, 8,  4'b0001, 8'hC6);
        addVec(16'hFEDC, 4'hF, 4'h0, 1'b0, 4'hF, 1, 8,  4'b0010, 8'hA1);
        addVec(16'hFEDC, 4'hF, 4'h0, 1'b0, 4'hF, 2, 8,  4'b0100, 8'h86);
        addVec(16'hFEDC, 4'hF, 4'h0, 1'b0, 4'hF, 3, 8,  4'b1000, 8'h8E);
        addVec(16'h3210, 4'hF, 4'h1, 1'b0, 4'hF, 0, 1,  4'b0001, 8'h40);

        rst_i = 1'b0;
        applyStimulus(16'h3210, 4'hF, 4'h0, 1'b0, 4'hF);
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 4'b0000, 8'hFF);
        checkInt("reset_frame", int'(frame_o), 0);
        releaseAndCount("power_on");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].data, vecs[i].en, vecs[i].dp, vecs[i].lz, vecs[i].bright);
            waitFrame();
            gotoSample(vecs[i].slot, vecs[i].phase);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_cx);
        end

        // Four lit phases per digit slot at brightness 4.
        applyStimulus(16'h3210, 4'hF, 4'h0, 1'b0, 4'h4);
        waitFrame();
        lit_cnt = 0;
        repeat (64) begin
            stepCycle();
            if (led_en_o !== 4'b0000) lit_cnt++;
        end
        checkInt("bright4_lit_cycles", lit_cnt, 16);

        // Brightness 0: permanently dark, frames still every 64 cycles.
        applyStimulus(16'h3210, 4'hF, 4'h0, 1'b0, 4'h0);
        waitFrame();
        lit_cnt = 0;
        while (pos < 200) begin
            stepCycle();
            if (led_en_o !== 4'b0000) lit_cnt++;
            if (frame_o === 1'b1) break;
        end
        checkInt("bright0_frame_period", pos, 64);
        checkInt("bright0_lit_cycles", lit_cnt, 0);

        // Mid-frame data change only takes effect at the next frame.
        applyStimulus(16'h1111, 4'hF, 4'h0, 1'b0, 4'hF);
        waitFrame();
        gotoSample(1, 3);
        applyStimulus(16'h2222, 4'hF, 4'h0, 1'b0, 4'hF);
        gotoSample(2, 3);
        checkOutput("midframe_digit2_old", 4'b0100, 8'hF9);
        gotoSample(3, 3);
        checkOutput("midframe_digit3_old", 4'b1000, 8'hF9);
        waitFrame();
        gotoSample(0, 3);
        checkOutput("nextframe_digit0_new", 4'b0001, 8'hA4);
        gotoSample(3, 3);
        checkOutput("nextframe_digit3_new", 4'b1000, 8'hA4);

        // One-cycle reset in the middle of a lit slot.
        applyStimulus(16'h3210, 4'hF, 4'h0, 1'b0, 4'hF);
        waitFrame();
        gotoSample(1, 5);
        checkOutput("pre_reset_lit", 4'b0010, 8'hF9);
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("midslot_reset_outputs", 4'b0000, 8'hFF);
        checkInt("midslot_reset_frame", int'(frame_o), 0);
        releaseAndCount("midslot_reset");
        gotoSample(0, 1);
        checkOutput("resumed_digit0", 4'b0001, 8'hC0);

        checkInt("onehot_violations", onehot_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
